// File: rtl/paddle_mux_ctl.sv
// paddle_mux_ctl: multi-channel paddle / analog stick / PS/2 mouse front end
// producing W-bit pot values and fire bits for the 2600 paddle inputs.
// Define PADDLE_SLEW_EN to rate-limit a_out with a free-running slew divider.
module paddle_mux_ctl #(
  parameter int NCH       = 4,
  parameter int W         = 8,
  parameter int MOUSE_CH  = 0,
  parameter int MCLAMP    = 10,
  parameter int STICK_THR = 100,
  parameter int SLEW_STEP = 4,
  parameter int SLEW_DIV  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inv,
  input  logic [NCH-1:0]    stick_btn,
  input  logic [NCH*16-1:0] joy_a,
  input  logic [NCH-1:0]    paddle_btn,
  input  logic [NCH*8-1:0]  paddle,
  input  logic [24:0]       ps2_mouse,
  output logic [NCH-1:0]    b_out,
  output logic [NCH*W-1:0]  a_out,
  output logic [NCH*2-1:0]  src
);

  typedef enum logic [1:0] {
    SRC_PADDLE = 2'd0,
    SRC_STICK  = 2'd1,
    SRC_MOUSE  = 2'd2
  } src_e;

  localparam logic signed [8:0] CLAMP_P = 9'(MCLAMP);
  localparam logic signed [8:0] CLAMP_N = -CLAMP_P;
  localparam logic signed [8:0] THR     = 9'(STICK_THR);
  localparam logic signed [9:0] SAT_HI  = 10'sd127;
  localparam logic signed [9:0] SAT_LO  = -10'sd128;

  src_e                 state_q [NCH];
  src_e                 state_d [NCH];
  logic [NCH-1:0]       xy_q, xy_d;
  logic [NCH-1:0]       b_d;
  logic [7:0]           t_d  [NCH];
  logic [7:0]           t_p0 [NCH];
  logic signed [8:0]    mx_q, my_q, mx_d, my_d;
  logic                 old_stb_q, armed_q, mevt;
  logic                 unused_bits;

  // Low delta bits and undecoded flags carry no information for the pot value.
  assign unused_bits = ^{ps2_mouse[16], ps2_mouse[8], ps2_mouse[7:6], ps2_mouse[3:2]};

  function automatic logic signed [8:0] clamp_delta(input logic signed [8:0] d);
    if (d > CLAMP_P)      return CLAMP_P;
    else if (d < CLAMP_N) return CLAMP_N;
    else                  return d;
  endfunction

  function automatic logic signed [8:0] sat_add(input logic signed [8:0] acc,
                                                input logic signed [8:0] d);
    logic signed [9:0] s;
    s = {acc[8], acc} + {d[8], d};
    if (s > SAT_HI)      return SAT_HI[8:0];
    else if (s < SAT_LO) return SAT_LO[8:0];
    else                 return s[8:0];
  endfunction

  function automatic logic signed [8:0] sx8(input logic [7:0] b);
    return {b[7], b};
  endfunction

  // Widen the 8-bit target by replicating its MSBs, then optionally invert.
  function automatic logic [W-1:0] widen(input logic [7:0] t, input logic inv_en);
    logic [15:0]  rep;
    logic [W-1:0] v;
    rep = {t, t};
    v   = rep[15 -: W];
    return inv_en ? ~v : v;
  endfunction

  // Strobe event, mouse accumulation, per-channel source/axis selection and target.
  always_comb begin
    mevt = armed_q && (old_stb_q != ps2_mouse[24]);
    mx_d = mx_q;
    my_d = my_q;
    if (mevt) begin
      mx_d = sat_add(mx_q, clamp_delta({ps2_mouse[4], ps2_mouse[4], ps2_mouse[15:9]}));
      my_d = sat_add(my_q, clamp_delta({ps2_mouse[5], ps2_mouse[5], ps2_mouse[23:17]}));
    end
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      xy_d[i]    = xy_q[i];
      b_d[i]     = 1'b0;
      t_d[i]     = 8'h00;
      case (state_q[i])
        SRC_MOUSE: begin
          if (ps2_mouse[0])      xy_d[i] = 1'b0;
          else if (ps2_mouse[1]) xy_d[i] = 1'b1;
        end
        SRC_STICK: begin
          if (sx8(joy_a[i*16 +: 8]) >= 9'sd0 && sx8(joy_a[i*16 +: 8]) > THR)
            xy_d[i] = 1'b0;
          else if (sx8(joy_a[i*16+8 +: 8]) >= 9'sd0 && sx8(joy_a[i*16+8 +: 8]) > THR)
            xy_d[i] = 1'b1;
        end
        default: ;
      endcase
      if (paddle_btn[i])              state_d[i] = SRC_PADDLE;
      else if (stick_btn[i])          state_d[i] = SRC_STICK;
      else if (i == MOUSE_CH && mevt) state_d[i] = SRC_MOUSE;
      case (state_d[i])
        SRC_STICK: b_d[i] = stick_btn[i];
        SRC_MOUSE: b_d[i] = |ps2_mouse[1:0];
        default:   b_d[i] = paddle_btn[i];
      endcase
      case (state_q[i])
        SRC_STICK: t_d[i] = xy_q[i] ? joy_a[i*16+8 +: 8] : joy_a[i*16 +: 8];
        SRC_MOUSE: t_d[i] = xy_q[i] ? my_q[7:0] : mx_q[7:0];
        default:   t_d[i] = {~paddle[i*8+7], paddle[i*8 +: 7]};
      endcase
    end
  end

  // Stage p0: source state, axis, fire bits, accumulators, strobe tracker, target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= SRC_PADDLE;
        t_p0[i]    <= 8'h00;
      end
      xy_q      <= '0;
      b_out     <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      old_stb_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        t_p0[i]    <= t_d[i];
      end
      xy_q      <= xy_d;
      b_out     <= b_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      old_stb_q <= ps2_mouse[24];
      armed_q   <= 1'b1;
    end
  end

  // Source code per channel, straight from the state register.
  always_comb begin
    src = '0;
    for (int i = 0; i < NCH; i++) src[i*2 +: 2] = state_q[i];
  end

`ifdef PADDLE_SLEW_EN
  localparam int             DW       = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(SLEW_DIV - 1);
  localparam logic [W-1:0]   STEP     = W'(SLEW_STEP);

  logic [DW-1:0] div_q;
  logic          slew_tick;

  assign slew_tick = (div_q == DIV_LAST);

  function automatic logic [W-1:0] slew_to(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    if (tgt > cur) return ((tgt - cur) > STEP) ? cur + STEP : tgt;
    else           return ((cur - tgt) > STEP) ? cur - STEP : tgt;
  endfunction

  // Stage p1: slew divider and rate-limited pot outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      a_out <= '0;
    end else begin
      div_q <= slew_tick ? '0 : div_q + 1'b1;
      if (slew_tick)
        for (int i = 0; i < NCH; i++)
          a_out[i*W +: W] <= slew_to(a_out[i*W +: W], widen(t_p0[i], inv));
    end
  end
`else
  logic [31:0] unused_slew;
  assign unused_slew = SLEW_STEP ^ SLEW_DIV;

  // Stage p1: widened, optionally inverted pot outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) a_out[i*W +: W] <= widen(t_p0[i], inv);
    end
  end
`endif

endmodule
